// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM state encoding and the busy-latency helper shared by
// md_iter_unit and its bench. The MACC state exists only when MD_MADD_EN is
// defined (multiply-accumulate ops 6-9).
package md_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3
`ifdef MD_MADD_EN
        ,
        ST_MACC = 3'd4
`endif
    } md_state_e;

    // Number of cycles busy stays high for an accepted op (0 for ops that
    // never raise busy).
    function automatic int md_latency(input logic [3:0] op, input int width,
                                      input int mul_bits);
        int lat;
        case (op)
            OP_MULT, OP_MULTU: lat = width / mul_bits + 1;
            OP_DIV, OP_DIVU:   lat = width + 1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: lat = width / mul_bits + 2;
`endif
            default:           lat = 0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/md_div_step.sv
// md_div_step: one combinational restoring-division step. Shifts the next
// dividend bit into the partial remainder and subtracts the divisor when it fits.
module md_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0]   shifted_s;
    logic [W-1:0] diff_s;

    // Trial subtraction; the difference always fits W bits when it is kept,
    // because rem_in < divisor implies shifted < 2*divisor.
    always_comb begin
        shifted_s = {rem_in, bit_in};
        diff_s    = shifted_s[W-1:0] - divisor;
        q_bit     = (shifted_s >= {1'b0, divisor});
        if (q_bit) begin
            rem_out = diff_s;
        end else begin
            rem_out = shifted_s[W-1:0];
        end
    end

endmodule

// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiplier (MUL_BITS bits per cycle) and restoring divider on
// magnitudes, with signs applied in FIX. Optional multiply-accumulate (ops 6-9)
// is enabled by defining MD_MADD_EN; otherwise those ops are no-ops.
module md_iter_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_BITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: product; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] opa_q, opa_d;     // mul: shifted multiplicand; div: divisor in low half
    logic [WIDTH-1:0]   opb_q, opb_d;     // mul: remaining multiplier bits
    logic               neg_q, neg_d;     // product / quotient must be negated
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;
    logic               divz_q, divz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
`ifdef MD_MADD_EN
    logic               macc_q, macc_d;
    logic               sub_q, sub_d;
`endif

    logic               accept_s, signed_s, sa_s, sb_s, mul_op_s, madd_op_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, div_rem_s, quo_fix_s, rem_fix_s;
    logic               div_q_s;
    logic [2*WIDTH-1:0] mul_sum_s, prod_fix_s;

    md_div_step #(.W(WIDTH)) u_div_step (
        .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
        .bit_in  (acc_q[WIDTH-1]),
        .divisor (opa_q[WIDTH-1:0]),
        .rem_out (div_rem_s),
        .q_bit   (div_q_s)
    );

    // Issue decode, datapath step and next-state selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        divz_d    = divz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef MD_MADD_EN
        macc_d    = macc_q;
        sub_d     = sub_q;
        madd_op_s = (op >= OP_MADD) && (op <= OP_MSUBU);
`else
        madd_op_s = 1'b0;
`endif
        accept_s  = start && !busy_q && !flush && !reset;
        mul_op_s  = (op == OP_MULT) || (op == OP_MULTU) || madd_op_s;
        signed_s  = (op == OP_MULT) || (op == OP_DIV) ||
                    (madd_op_s && !op[0]);
        sa_s      = signed_s && a[WIDTH-1];
        sb_s      = signed_s && b[WIDTH-1];
        mag_a_s   = sa_s ? -a : a;
        mag_b_s   = sb_s ? -b : b;

        mul_sum_s = acc_q;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (opb_q[i]) begin
                mul_sum_s = mul_sum_s + (opa_q << i);
            end else begin
                mul_sum_s = mul_sum_s;
            end
        end
        prod_fix_s = neg_q ? -acc_q : acc_q;
        quo_fix_s  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix_s  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            ST_IDLE: begin
                if (accept_s && mul_op_s) begin
                    state_d  = ST_MUL;
                    cnt_d    = MUL_LAST;
                    acc_d    = '0;
                    opa_d    = {{WIDTH{1'b0}}, mag_a_s};
                    opb_d    = mag_b_s;
                    neg_d    = sa_s ^ sb_s;
                    is_div_d = 1'b0;
`ifdef MD_MADD_EN
                    macc_d   = madd_op_s;
                    sub_d    = madd_op_s && (op >= OP_MSUB);
`endif
                end else if (accept_s && ((op == OP_DIV) || (op == OP_DIVU))) begin
                    state_d   = ST_DIV;
                    cnt_d     = DIV_LAST;
                    acc_d     = {{WIDTH{1'b0}}, mag_a_s};
                    opa_d     = {{WIDTH{1'b0}}, mag_b_s};
                    neg_d     = sa_s ^ sb_s;
                    neg_rem_d = sa_s;
                    is_div_d  = 1'b1;
                    divz_d    = (b == {WIDTH{1'b0}});
                end else if (accept_s && (op == OP_MTHI)) begin
                    hi_d = a;
                end else if (accept_s && (op == OP_MTLO)) begin
                    lo_d = a;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d = mul_sum_s;
                opa_d = opa_q << MUL_BITS;
                opb_d = opb_q >> MUL_BITS;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
`ifdef MD_MADD_EN
                    state_d = macc_q ? ST_MACC : ST_FIX;
`else
                    state_d = ST_FIX;
`endif
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DIV: begin
                // With a zero divisor every step keeps the shifted value, so the
                // remainder ends as |a|; the sign fix in FIX turns it back into a.
                acc_d = {div_rem_s, acc_q[WIDTH-2:0], div_q_s};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
`ifdef MD_MADD_EN
            ST_MACC: begin
                // Sign already folded in here, so FIX writes the sum unchanged.
                if (sub_q) begin
                    acc_d = {hi_q, lo_q} - prod_fix_s;
                end else begin
                    acc_d = {hi_q, lo_q} + prod_fix_s;
                end
                neg_d   = 1'b0;
                state_d = ST_FIX;
            end
`endif
            ST_FIX: begin
                if (is_div_q) begin
                    lo_d = divz_q ? {WIDTH{1'b1}} : quo_fix_s;
                    hi_d = rem_fix_s;
                end else begin
                    {hi_d, lo_d} = prod_fix_s;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort discards the op, including a pending FIX write-back.
        if (flush && busy_q) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end else begin
            state_d = state_d;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and HI/LO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            divz_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
`ifdef MD_MADD_EN
            macc_q    <= 1'b0;
            sub_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            divz_q    <= divz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
`ifdef MD_MADD_EN
            macc_q    <= macc_d;
            sub_q     <= sub_d;
`endif
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/md_iter_unit.md
# md_iter_unit

Parametrised multi-cycle multiply/divide unit holding the architectural HI/LO registers for the MIPS datapath, driven from the EX stage. It replaces single-cycle arithmetic with an iterative shift-add multiplier and a restoring divider, and reports real occupancy through `busy`. It adds a pipeline `flush` abort, defined divide-by-zero and overflow results, and optional multiply-accumulate. The hazard unit stalls HI/LO-dependent instructions while `busy` is high.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be even and ≥ 8.
- `MUL_BITS`, 2: multiplier bits retired per cycle; must be 1, 2 or 4 and must divide `WIDTH`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  issue strobe, sampled with `op`, `a` and `b`.
- `flush`  in  1  abort any in-flight operation; HI/LO are not updated.
- `op`  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10–15 are no-ops.
- `a`  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `busy`  out  1  high while an operation is in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **States:** IDLE, MUL, DIV, FIX. Also MACC when `MD_MADD_EN` is defined. Iteration counter is `$clog2(WIDTH)+1` bits.
- **Accept rule:** an issue is accepted only when `start` is high, `busy` is low, `flush` is low, and `reset` is low. Any `start` seen while `busy` is high is ignored.
- **Signed ops:** operands are converted to magnitudes and the sign flags are latched. The unsigned core runs, and FIX applies the result signs.
- **Multiply (MUL):**
  - Adds `MUL_BITS` partial products per cycle into a 2·WIDTH accumulator.
  - Runs WIDTH/`MUL_BITS` cycles, then goes to FIX.
- **Divide (DIV):**
  - Restoring division, one quotient bit per cycle, for WIDTH cycles, then FIX.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Divisor 0: LO = all-ones, HI = `a`, for signed and unsigned ops alike. The operation keeps the normal latency.
  - Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
- **FIX:** writes `{hi,lo}` for multiply, or LO = quotient and HI = remainder for divide. Then returns to IDLE.
- **MTHI/MTLO:** if accepted, writes `hi` or `lo` on that same edge; `busy` stays low. If not accepted, no effect.
- **HI/LO during an operation:** they hold their old values until the FIX edge, so reads in that window return pre-operation values.
- **Flush:**
  - `flush` while busy: return to IDLE next edge, `busy` low, HI/LO unchanged.
  - `flush` together with `start`: nothing is started.
- **Reset:** `busy` = 0, `hi` = 0, `lo` = 0, state = IDLE. Reset overrides everything, including mid-operation.

## Timing
- **Issue edge:** on the edge that accepts a MULT/DIV-class op, operands are latched and `busy` is 1 from the next cycle.
- **Multiply latency:** `busy` is high for WIDTH/`MUL_BITS` + 1 cycles; 17 with defaults.
- **Divide latency:** `busy` is high for WIDTH + 1 cycles; 33 with defaults.
- **Result timing:** HI/LO update on the same edge that drops `busy`. The next op can be issued in the first cycle `busy` is low.
- **Back-to-back issue:** no bubble between operations.
- **MTHI/MTLO:** zero latency, no `busy`.

## Configuration
- **`MD_MADD_EN` defined:**
  - Ops 6–9 run a multiply, then go MUL → MACC → FIX.
  - MACC computes `{hi,lo}` ± product, with 2·WIDTH wraparound.
  - Latency is one cycle longer than a plain multiply.
- **`MD_MADD_EN` undefined:** ops 6–9 are no-ops; `busy` stays 0 and HI/LO are unchanged.

## Structure
- **Package `md_pkg`:** op-code localparams, the state enum, and a function returning cycle latency from (op, WIDTH, `MUL_BITS`). The bench uses this function.
- **Sub-module `md_div_step`:** one combinational restoring-division step (partial remainder and divisor in; next remainder and quotient bit out), instantiated once.

## Test plan
- **MULT:** −3 × 5 → after 17 busy cycles, HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- **DIV:** −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 33 busy cycles. Also 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero:** DIVU 7 / 0 → LO = 0xFFFFFFFF, HI = 7.
- **Flush mid-op:**
  - Setup: MTLO 0x1234, then DIV, then `flush` on busy cycle 10.
  - Expect: `busy` low next cycle and LO = 0x1234.
  - A `start` issued during `busy` is ignored.
- **MADD with `MD_MADD_EN`:** from HI = 0, LO = 1, MADD 2 × 3 → LO = 7, HI = 0, after 18 busy cycles. Without the macro: `busy` stays 0 and LO = 1.
